// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush control bundle between the pipeline hazard sources and the
// central stall sequencer. The master side raises requests; the slave side
// (the sequencer) returns the stall vector, flush and status.
interface pipe_stall_ctrl_if #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
);
    logic                id_stallreq;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                ex_mc_abort;
    logic                flush_req;
    logic [5:0]          stall_o;
    logic                flush_o;
    logic                ex_mc_done;
    logic                busy_o;
    logic [PERF_W-1:0]   stall_cnt_o;

    modport master (
        output id_stallreq, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req,
        input  stall_o, flush_o, ex_mc_done, busy_o, stall_cnt_o
    );

    modport slave (
        input  id_stallreq, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req,
        output stall_o, flush_o, ex_mc_done, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Merges the ID load-use stall, EX multi-cycle requests and flush into one
// stall vector, runs the multi-cycle countdown FSM and keeps a saturating
// count of stalled cycles.
module pipe_stall_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_stall_ctrl_if.slave       ctl
);

    // Stall vector bits: [0]PC [1]IF_ID [2]ID_EX [3]EX_MEM [4]MEM_WB [5]reserved
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic {
        IDLE   = 1'b0,
        MC_RUN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic [PERF_W-1:0]   perf_q;
    logic [5:0]          stall;
    logic                flush;
    logic                done;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

    // State and countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and same-cycle stall/flush/done decode; priority is
    // flush > abort > multi-cycle stall > ID load-use stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        done    = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ctl.flush_req) begin
                        flush = 1'b1;
                    end else if (ctl.ex_mc_start && (ctl.ex_mc_cycles != '0)) begin
                        stall = STALL_EX;
                        if (ctl.ex_mc_cycles == MC_CNT_W'(1)) begin
                            // Single-cycle op completes in its start cycle.
                            done = 1'b1;
                        end else begin
                            // Start cycle counts as the first of N stall cycles.
                            cnt_d   = ctl.ex_mc_cycles - MC_CNT_W'(1);
                            state_d = MC_RUN;
                        end
                    end else if (ctl.id_stallreq) begin
                        stall = STALL_ID;
                    end
                end
                MC_RUN: begin
                    if (ctl.flush_req) begin
                        flush   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ctl.ex_mc_abort) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        // The wider EX stall already covers a concurrent ID request.
                        stall = STALL_EX;
                        if (cnt_q == MC_CNT_W'(1)) begin
                            done    = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - MC_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stall-cycle performance counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall != STALL_NONE) begin
            perf_q <= sat_inc(perf_q);
        end
    end

    // Outputs are held at zero for as long as reset is asserted.
    always_comb begin
        ctl.stall_o     = stall;
        ctl.flush_o     = flush;
        ctl.ex_mc_done  = done;
        ctl.busy_o      = (state_q == MC_RUN) && !rst;
        ctl.stall_cnt_o = rst ? '0 : perf_q;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge of the same cycle.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst;
    logic rst_s;

    int n_tests;
    int n_fail;

    pipe_stall_ctrl_if #(.MC_CNT_W(6), .PERF_W(32)) bus ();
    pipe_stall_ctrl_if #(.MC_CNT_W(6), .PERF_W(4))  bus_s ();

    pipe_stall_ctrl #(.MC_CNT_W(6), .PERF_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus.slave)
    );

    pipe_stall_ctrl #(.MC_CNT_W(6), .PERF_W(4)) u_sat (
        .clk (clk),
        .rst (rst_s),
        .ctl (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs to the main instance and move to mid-cycle.
    task automatic cyc(input logic id, input logic start, input logic [5:0] n,
                       input logic abort, input logic flush);
        @(posedge clk);
        #1;
        bus.id_stallreq  = id;
        bus.ex_mc_start  = start;
        bus.ex_mc_cycles = n;
        bus.ex_mc_abort  = abort;
        bus.flush_req    = flush;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                           input logic dn, input logic bz);
        check({tag, ".stall"}, 32'(bus.stall_o), 32'(st));
        check({tag, ".flush"}, 32'(bus.flush_o), 32'(fl));
        check({tag, ".done"},  32'(bus.ex_mc_done), 32'(dn));
        check({tag, ".busy"},  32'(bus.busy_o), 32'(bz));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset with active requests: everything must stay quiet.
        rst = 1'b1;
        rst_s = 1'b1;
        bus.id_stallreq  = 1'b1;
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd4;
        bus.ex_mc_abort  = 1'b0;
        bus.flush_req    = 1'b0;
        bus_s.id_stallreq  = 1'b0;
        bus_s.ex_mc_start  = 1'b0;
        bus_s.ex_mc_cycles = 6'd0;
        bus_s.ex_mc_abort  = 1'b0;
        bus_s.flush_req    = 1'b0;
        @(negedge clk);
        chk_out("rst0", 6'h00, 1'b0, 1'b0, 1'b0);
        check("rst0.cnt", bus.stall_cnt_o, 32'd0);
        cyc(1'b1, 1'b1, 6'd4, 1'b0, 1'b0);
        chk_out("rst1", 6'h00, 1'b0, 1'b0, 1'b0);
        check("rst1.cnt", bus.stall_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_s = 1'b0;
        bus.id_stallreq = 1'b0;
        bus.ex_mc_start = 1'b0;
        @(negedge clk);
        chk_out("rel", 6'h00, 1'b0, 1'b0, 1'b0);
        check("rel.cnt", bus.stall_cnt_o, 32'd0);

        // Single-cycle load-use stall.
        cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("id", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("id.after", 6'h00, 1'b0, 1'b0, 1'b0);
        check("id.cnt", bus.stall_cnt_o, 32'd1);

        // N=4 multi-cycle op, with a concurrent ID request in cycle 2.
        cyc(1'b0, 1'b1, 6'd4, 1'b0, 1'b0);
        chk_out("mc4.c1", 6'b001111, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 6'd2, 1'b0, 1'b0);
        chk_out("mc4.c2", 6'b001111, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("mc4.c3", 6'b001111, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("mc4.c4", 6'b001111, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("mc4.c5", 6'h00, 1'b0, 1'b0, 1'b0);
        check("mc4.cnt", bus.stall_cnt_o, 32'd5);   // 1 earlier + 4

        // N=1 and N=0.
        cyc(1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
        chk_out("mc1.c1", 6'b001111, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("mc1.c2", 6'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
        chk_out("mc0.c1", 6'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("mc0.c2", 6'h00, 1'b0, 1'b0, 1'b0);
        check("mc0.cnt", bus.stall_cnt_o, 32'd6);

        // N=8 flushed in cycle 3.
        cyc(1'b0, 1'b1, 6'd8, 1'b0, 1'b0);
        chk_out("fl.c1", 6'b001111, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("fl.c2", 6'b001111, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
        chk_out("fl.c3", 6'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("fl.c4", 6'h00, 1'b0, 1'b0, 1'b0);
        check("fl.cnt", bus.stall_cnt_o, 32'd8);

        // N=8 aborted in cycle 3.
        cyc(1'b0, 1'b1, 6'd8, 1'b0, 1'b0);
        chk_out("ab.c1", 6'b001111, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("ab.c2", 6'b001111, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        chk_out("ab.c3", 6'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("ab.c4", 6'h00, 1'b0, 1'b0, 1'b0);
        check("ab.cnt", bus.stall_cnt_o, 32'd10);

        // Abort in IDLE is ignored; flush in IDLE beats a start.
        cyc(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        chk_out("abidle", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 6'd5, 1'b0, 1'b1);
        chk_out("flidle.c1", 6'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("flidle.c2", 6'h00, 1'b0, 1'b0, 1'b0);
        check("flidle.cnt", bus.stall_cnt_o, 32'd11);

        // Reset in the middle of a multi-cycle op.
        cyc(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        chk_out("rmid.c1", 6'b001111, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk_out("rmid.c2", 6'b001111, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_out("rmid.rst", 6'h00, 1'b0, 1'b0, 1'b0);
        check("rmid.rstcnt", bus.stall_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_out("rmid.rel", 6'h00, 1'b0, 1'b0, 1'b0);
        check("rmid.relcnt", bus.stall_cnt_o, 32'd0);

        // Saturation of a 4-bit counter under a 20-cycle ID stall.
        @(posedge clk);
        #1;
        bus_s.id_stallreq = 1'b1;
        @(negedge clk);
        check("sat.stall", 32'(bus_s.stall_o), 32'b000111);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sat.mid", 32'(bus_s.stall_cnt_o), 32'd10);
        repeat (10) @(posedge clk);
        #1;
        bus_s.id_stallreq = 1'b0;
        @(negedge clk);
        check("sat.max", 32'(bus_s.stall_cnt_o), 32'd15);
        @(posedge clk);
        #1;
        rst_s = 1'b1;
        @(negedge clk);
        check("sat.rst", 32'(bus_s.stall_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        @(negedge clk);
        check("sat.rel", 32'(bus_s.stall_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
